// File: rtl/sync_cmd_exec.sv
// Command synchronisation/execution stage: requests the next due command, waits
// for its start time, then plays out the pulse train, blanking and NCO words.
module sync_cmd_exec #(
  parameter int unsigned REQ_TIMEOUT = 1024,
  parameter int unsigned MIN_LEAD    = 2
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic [63:0] TIME,
  input  logic        SYS_TIME_UPDATE,
  input  logic        DATA_WR,
  input  logic [47:0] FREQ,
  input  logic [47:0] FREQ_STEP,
  input  logic [31:0] FREQ_RATE,
  input  logic [63:0] TIME_START,
  input  logic [15:0] N_impulse,
  input  logic [1:0]  TYPE_impulse,
  input  logic [31:0] Interval_Ti,
  input  logic [31:0] Interval_Tp,
  input  logic [31:0] Tblank1,
  input  logic [31:0] Tblank2,
  output logic        REQ_COMM,
  output logic        IMPULSE,
  output logic        BLANK,
  output logic [47:0] NCO_FREQ,
  output logic        NCO_FREQ_WR,
  output logic        BUSY,
  output logic        ERR_LATE,
  output logic        CMD_REJECT
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT_DATA, S_CHECK, S_ARMED, S_PULSE, S_TAIL
  } state_t;

  state_t      state_q;
  logic [31:0] tmo_q;
  logic [63:0] tlat_q, tstart_q;
  logic [47:0] freq_q, step_q, acc_q;
  logic [31:0] rate_q, ti_q, tp_q, tb1_q, tb2_q;
  logic [15:0] n_q, k_q;
  logic [1:0]  type_q;
  logic [31:0] p_q, rc_q, t_q;

  logic        req_q, imp_q, blank_q, wr_q, busy_q, late_q, rej_q;
  logic [47:0] nco_q;

  // Position of the next cycle inside the train; rc tracks p modulo Rate_eff
  logic        last_p, last_k;
  logic [31:0] p_d, rc_d;
  logic [15:0] k_d;

  always_comb begin
    last_p = (p_q == tp_q - 32'd1);
    last_k = (k_q == n_q - 16'd1);
    p_d    = last_p ? '0 : p_q + 32'd1;
    k_d    = last_p ? k_q + 16'd1 : k_q;
    rc_d   = (last_p || rc_q == rate_q - 32'd1) ? '0 : rc_q + 32'd1;
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      tmo_q    <= '0;
      tlat_q   <= '0;
      tstart_q <= '0;
      freq_q   <= '0;
      step_q   <= '0;
      acc_q    <= '0;
      rate_q   <= '0;
      ti_q     <= '0;
      tp_q     <= '0;
      tb1_q    <= '0;
      tb2_q    <= '0;
      n_q      <= '0;
      k_q      <= '0;
      type_q   <= '0;
      p_q      <= '0;
      rc_q     <= '0;
      t_q      <= '0;
      req_q    <= 1'b0;
      imp_q    <= 1'b0;
      blank_q  <= 1'b0;
      wr_q     <= 1'b0;
      busy_q   <= 1'b0;
      late_q   <= 1'b0;
      rej_q    <= 1'b0;
      nco_q    <= '0;
    end else begin
      req_q  <= 1'b0;
      wr_q   <= 1'b0;
      late_q <= 1'b0;
      rej_q  <= 1'b0;
      if (SYS_TIME_UPDATE && state_q != S_IDLE) begin
        state_q <= S_IDLE;
        imp_q   <= 1'b0;
        blank_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (!SYS_TIME_UPDATE) begin
              state_q <= S_REQ;
              req_q   <= 1'b1;
            end
          end
          S_REQ: begin
            state_q <= S_WAIT_DATA;
            tmo_q   <= '0;
          end
          S_WAIT_DATA: begin
            if (DATA_WR) begin
              freq_q   <= FREQ;
              step_q   <= FREQ_STEP;
              rate_q   <= (FREQ_RATE == '0) ? 32'd1 : FREQ_RATE;
              tstart_q <= TIME_START;
              tlat_q   <= TIME;
              n_q      <= N_impulse;
              type_q   <= (TYPE_impulse == 2'd3) ? 2'd0 : TYPE_impulse;
              tp_q     <= Interval_Tp;
              ti_q     <= (Interval_Ti < Interval_Tp) ? Interval_Ti : Interval_Tp;
              tb1_q    <= Tblank1;
              tb2_q    <= Tblank2;
              state_q  <= S_CHECK;
            end else if (tmo_q == REQ_TIMEOUT - 1) begin
              state_q <= S_IDLE;
            end else begin
              tmo_q <= tmo_q + 32'd1;
            end
          end
          S_CHECK: begin
            if (n_q == '0 || tp_q == '0) begin
              rej_q   <= 1'b1;
              state_q <= S_IDLE;
            end else if (tstart_q < tlat_q + 64'(MIN_LEAD)) begin
              late_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              nco_q   <= freq_q;
              wr_q    <= 1'b1;
              busy_q  <= 1'b1;
              blank_q <= 1'b0;
              state_q <= S_ARMED;
            end
          end
          S_ARMED: begin
            blank_q <= (TIME + {32'd0, tb1_q} >= tstart_q);
            if (TIME >= tstart_q) begin
              state_q <= S_PULSE;
              p_q     <= '0;
              k_q     <= '0;
              rc_q    <= '0;
              blank_q <= 1'b1;
              imp_q   <= (ti_q != '0);
              acc_q   <= freq_q + step_q;
              if (type_q != 2'd0) begin
                nco_q <= freq_q;
                wr_q  <= 1'b1;
              end
            end
          end
          S_PULSE: begin
            if (last_p && last_k) begin
              imp_q <= 1'b0;
              t_q   <= '0;
              if (tb2_q == '0) begin
                blank_q <= 1'b0;
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end else begin
                state_q <= S_TAIL;
              end
            end else begin
              p_q   <= p_d;
              k_q   <= k_d;
              rc_q  <= rc_d;
              imp_q <= (p_d < ti_q);
              if (last_p) begin
                if (type_q == 2'd1) begin
                  nco_q <= freq_q;
                  wr_q  <= 1'b1;
                end else if (type_q == 2'd2) begin
                  nco_q <= acc_q;
                  acc_q <= acc_q + step_q;
                  wr_q  <= 1'b1;
                end
              end else if (type_q == 2'd1 && p_d < ti_q && rc_d == '0) begin
                nco_q <= nco_q + step_q;
                wr_q  <= 1'b1;
              end
            end
          end
          S_TAIL: begin
            if (t_q == tb2_q - 32'd1) begin
              blank_q <= 1'b0;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              t_q <= t_q + 32'd1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign REQ_COMM    = req_q;
  assign IMPULSE     = imp_q;
  assign BLANK       = blank_q;
  assign NCO_FREQ    = nco_q;
  assign NCO_FREQ_WR = wr_q;
  assign BUSY        = busy_q;
  assign ERR_LATE    = late_q;
  assign CMD_REJECT  = rej_q;

endmodule

// File: tb/tb_sync_cmd_exec.sv
// Bench for sync_cmd_exec: acts as the command memory and predicts every output
// cycle from the command's timing rules (start time, period, width, tail).
module tb_sync_cmd_exec;
  localparam int unsigned TMO = 16;

  logic        CLK = 1'b0;
  logic        rst;
  logic [63:0] TIME;
  logic        SYS_TIME_UPDATE, DATA_WR;
  logic [47:0] FREQ, FREQ_STEP;
  logic [31:0] FREQ_RATE;
  logic [63:0] TIME_START;
  logic [15:0] N_impulse;
  logic [1:0]  TYPE_impulse;
  logic [31:0] Interval_Ti, Interval_Tp, Tblank1, Tblank2;
  logic        REQ_COMM, IMPULSE, BLANK, NCO_FREQ_WR, BUSY, ERR_LATE, CMD_REJECT;
  logic [47:0] NCO_FREQ;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [47:0] nco_exp;

  logic [47:0] c_freq, c_step;
  logic [31:0] c_rate, c_ti, c_tp, c_tb1, c_tb2;
  logic [15:0] c_n;
  logic [1:0]  c_type;
  logic [63:0] c_ts, c_lead;
  bit          c_abs;

  sync_cmd_exec #(.REQ_TIMEOUT(TMO), .MIN_LEAD(2)) dut (
    .CLK(CLK), .rst(rst), .TIME(TIME), .SYS_TIME_UPDATE(SYS_TIME_UPDATE),
    .DATA_WR(DATA_WR), .FREQ(FREQ), .FREQ_STEP(FREQ_STEP), .FREQ_RATE(FREQ_RATE),
    .TIME_START(TIME_START), .N_impulse(N_impulse), .TYPE_impulse(TYPE_impulse),
    .Interval_Ti(Interval_Ti), .Interval_Tp(Interval_Tp), .Tblank1(Tblank1),
    .Tblank2(Tblank2), .REQ_COMM(REQ_COMM), .IMPULSE(IMPULSE), .BLANK(BLANK),
    .NCO_FREQ(NCO_FREQ), .NCO_FREQ_WR(NCO_FREQ_WR), .BUSY(BUSY),
    .ERR_LATE(ERR_LATE), .CMD_REJECT(CMD_REJECT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    TIME = TIME + 64'd1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at TIME=%0d: observed=0x%0h expected=0x%0h", tag, TIME, obs, exp);
    end
  endtask

  task automatic cyc(input bit rq, input bit imp, input bit blk, input bit bsy,
                     input bit lt, input bit rj, input logic [47:0] nco, input bit wr);
    chk("REQ_COMM", 64'(REQ_COMM), 64'(rq));
    chk("IMPULSE", 64'(IMPULSE), 64'(imp));
    chk("BLANK", 64'(BLANK), 64'(blk));
    chk("BUSY", 64'(BUSY), 64'(bsy));
    chk("ERR_LATE", 64'(ERR_LATE), 64'(lt));
    chk("CMD_REJECT", 64'(CMD_REJECT), 64'(rj));
    chk("NCO_FREQ", 64'(NCO_FREQ), 64'(nco));
    chk("NCO_FREQ_WR", 64'(NCO_FREQ_WR), 64'(wr));
  endtask

  // Random field values with an occasional stray strobe that must be ignored
  task automatic junk();
    DATA_WR      = ($urandom_range(3) == 0);
    FREQ         = 48'({$urandom(), $urandom()});
    FREQ_STEP    = 48'({$urandom(), $urandom()});
    FREQ_RATE    = $urandom();
    TIME_START   = {$urandom(), $urandom()};
    N_impulse    = 16'($urandom());
    TYPE_impulse = 2'($urandom());
    Interval_Ti  = $urandom();
    Interval_Tp  = $urandom();
    Tblank1      = $urandom();
    Tblank2      = $urandom();
  endtask

  task automatic drive_cmd();
    DATA_WR      = 1'b1;
    FREQ         = c_freq;
    FREQ_STEP    = c_step;
    FREQ_RATE    = c_rate;
    TIME_START   = c_ts;
    N_impulse    = c_n;
    TYPE_impulse = c_type;
    Interval_Ti  = c_ti;
    Interval_Tp  = c_tp;
    Tblank1      = c_tb1;
    Tblank2      = c_tb2;
  endtask

  task automatic set_cmd(input logic [47:0] f, input logic [47:0] s, input logic [31:0] r,
                         input logic [15:0] n, input logic [1:0] ty, input logic [31:0] ti,
                         input logic [31:0] tp, input logic [31:0] b1, input logic [31:0] b2,
                         input logic [63:0] lead);
    c_freq = f; c_step = s; c_rate = r; c_n = n; c_type = ty;
    c_ti = ti; c_tp = tp; c_tb1 = b1; c_tb2 = b2; c_lead = lead; c_abs = 1'b0;
  endtask

  // Entered in a cycle where REQ_COMM is high; returns in the next such cycle.
  task automatic run_cmd(input int delay, input int stop_off, input bit use_rst);
    logic [63:0] tw, t, t_last, t_idle, t_req, i, p, k, pe;
    logic [31:0] ti_eff, rate_eff;
    logic [1:0]  ty;
    logic [47:0] e_nco, kk;
    bit          rej, late, e_imp, e_blk, e_bsy, e_wr, e_req;
    junk();
    tick();
    for (int j = 0; j < delay; j++) begin
      cyc(0, 0, 0, 0, 0, 0, nco_exp, 0);
      DATA_WR = 1'b0;
      tick();
    end
    cyc(0, 0, 0, 0, 0, 0, nco_exp, 0);
    tw = TIME;
    if (!c_abs) c_ts = TIME + c_lead;
    drive_cmd();
    tick();
    cyc(0, 0, 0, 0, 0, 0, nco_exp, 0);
    junk();
    tick();
    rej  = (c_n == 16'd0) || (c_tp == 32'd0);
    late = !rej && (c_ts < tw + 64'd2);
    if (rej || late) begin
      cyc(0, 0, 0, 0, late, rej, nco_exp, 0);
      junk();
      tick();
      cyc(1, 0, 0, 0, 0, 0, nco_exp, 0);
      return;
    end
    ti_eff   = (c_ti < c_tp) ? c_ti : c_tp;
    rate_eff = (c_rate == 32'd0) ? 32'd1 : c_rate;
    ty       = (c_type == 2'd3) ? 2'd0 : c_type;
    t_last   = c_ts + 64'(c_n) * 64'(c_tp);
    t_idle   = t_last + 64'(c_tb2) + 64'd1;
    t_req    = t_idle + 64'd1;
    while (TIME <= t_req) begin
      t = TIME;
      e_req = 0; e_imp = 0; e_blk = 0; e_bsy = 0; e_wr = 0; e_nco = nco_exp;
      if (t == tw + 64'd2) begin
        e_bsy = 1; e_nco = c_freq; e_wr = 1;
      end else if (t <= c_ts) begin
        e_bsy = 1;
        e_blk = (t - 64'd1 + 64'(c_tb1) >= c_ts);
      end else if (t <= t_last) begin
        i = t - c_ts - 64'd1;
        k = i / 64'(c_tp);
        p = i % 64'(c_tp);
        e_bsy = 1; e_blk = 1;
        e_imp = (p < 64'(ti_eff));
        if (ty == 2'd1) begin
          pe    = (ti_eff == 0) ? 64'd0 : ((p < 64'(ti_eff)) ? p : 64'(ti_eff) - 64'd1);
          e_nco = c_freq + 48'(pe / 64'(rate_eff)) * c_step;
          e_wr  = (p == 0) || (p < 64'(ti_eff) && (p % 64'(rate_eff)) == 0);
        end else if (ty == 2'd2) begin
          kk    = 48'(k);
          e_nco = c_freq + kk * c_step;
          e_wr  = (p == 0);
        end
      end else if (t < t_idle) begin
        e_bsy = 1; e_blk = 1;
      end else if (t == t_req) begin
        e_req = 1;
      end
      nco_exp = e_nco;
      cyc(e_req, e_imp, e_blk, e_bsy, 0, 0, e_nco, e_wr);
      if (t == t_req) return;
      if (stop_off != 0 && t == tw + 64'(stop_off)) begin
        if (use_rst) begin
          #2;
          rst = 1'b1;
          #1;
          nco_exp = '0;
          cyc(0, 0, 0, 0, 0, 0, nco_exp, 0);
          tick();
          cyc(0, 0, 0, 0, 0, 0, nco_exp, 0);
          rst = 1'b0;
          tick();
          cyc(1, 0, 0, 0, 0, 0, nco_exp, 0);
        end else begin
          SYS_TIME_UPDATE = 1'b1;
          junk();
          tick();
          for (int j = 1; j <= 5; j++) begin
            cyc(0, 0, 0, 0, 0, 0, nco_exp, 0);
            if (j == 5) SYS_TIME_UPDATE = 1'b0;
            junk();
            tick();
          end
          cyc(1, 0, 0, 0, 0, 0, nco_exp, 0);
        end
        return;
      end
      junk();
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    TIME = 64'd990;
    SYS_TIME_UPDATE = 1'b0;
    junk();
    DATA_WR = 1'b0;
    nco_exp = '0;
    tick();
    cyc(0, 0, 0, 0, 0, 0, 48'd0, 0);
    tick();
    cyc(0, 0, 0, 0, 0, 0, 48'd0, 0);
    rst = 1'b0;
    tick();
    cyc(1, 0, 0, 0, 0, 0, 48'd0, 0);

    // Basic train with absolute start time
    set_cmd(48'h123, 48'd7, 32'd1, 16'd3, 2'd0, 32'd4, 32'd10, 32'd5, 32'd6, 64'd0);
    c_abs = 1'b1;
    c_ts  = 64'd1100;
    run_cmd(0, 0, 0);
    // Intra-pulse sweep
    set_cmd(48'd100, 48'd5, 32'd2, 16'd2, 2'd1, 32'd6, 32'd8, 32'd3, 32'd2, 64'd5);
    run_cmd(1, 0, 0);
    // Pulse-to-pulse step across the 48-bit wrap, no tail
    set_cmd(48'hFFFF_FFFF_FFFE, 48'd1, 32'd1, 16'd4, 2'd2, 32'd1, 32'd3, 32'd0, 32'd0, 64'd4);
    run_cmd(0, 0, 0);
    // Late by one, zero pulses, zero period
    set_cmd(48'd9, 48'd1, 32'd1, 16'd1, 2'd0, 32'd1, 32'd1, 32'd0, 32'd0, 64'd1);
    run_cmd(2, 0, 0);
    set_cmd(48'd9, 48'd1, 32'd1, 16'd0, 2'd0, 32'd1, 32'd4, 32'd0, 32'd0, 64'd20);
    run_cmd(0, 0, 0);
    set_cmd(48'd9, 48'd1, 32'd1, 16'd2, 2'd0, 32'd1, 32'd0, 32'd0, 32'd0, 64'd20);
    run_cmd(0, 0, 0);
    // Minimum lead, width clamped to period, zero rate, type 3
    set_cmd(48'd50, 48'd3, 32'd0, 16'd2, 2'd3, 32'd9, 32'd3, 32'd1, 32'd1, 64'd2);
    run_cmd(0, 0, 0);
    // Sweep with rate 0 behaving as 1
    set_cmd(48'd1000, 48'd10, 32'd0, 16'd1, 2'd1, 32'd3, 32'd5, 32'd0, 32'd1, 64'd3);
    run_cmd(0, 0, 0);

    for (int r = 0; r < 12; r++) begin
      set_cmd(48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}),
              $urandom_range(3), 16'($urandom_range(4)), 2'($urandom_range(3)),
              $urandom_range(7), $urandom_range(6), $urandom_range(8),
              $urandom_range(3), 64'($urandom_range(15)));
      run_cmd(int'($urandom_range(3)), 0, 0);
    end

    // No reply: request repeats every TMO+2 cycles
    DATA_WR = 1'b0;
    tick();
    for (int i = 1; i <= 2 * (TMO + 2); i++) begin
      cyc((i % (TMO + 2)) == 0, 0, 0, 0, 0, 0, nco_exp, 0);
      if (i != 2 * (TMO + 2)) tick();
    end

    // Time reload mid-pulse, then asynchronous reset mid-pulse
    set_cmd(48'd77, 48'd2, 32'd1, 16'd3, 2'd2, 32'd4, 32'd10, 32'd2, 32'd2, 64'd4);
    run_cmd(0, 7, 0);
    set_cmd(48'd88, 48'd2, 32'd1, 16'd3, 2'd1, 32'd4, 32'd10, 32'd2, 32'd2, 64'd4);
    run_cmd(0, 17, 1);
    set_cmd(48'd5, 48'd1, 32'd1, 16'd2, 2'd2, 32'd2, 32'd4, 32'd1, 32'd1, 64'd6);
    run_cmd(1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
